// File: rtl/hex_entry_pkg.sv
// Shared definitions for the hex digit entry front end: digit geometry and
// the entry FSM state encoding.
package hex_entry_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DIGITS     = DEF_DATA_W / DIGIT_W;

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } entry_state_t;

endpackage

// File: rtl/hex_entry_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// registered falling-edge (press) detector on the debounced level.
module hex_entry_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw_n;
            sync2   <= sync1;
            level_d <= level;
            press   <= level_d & ~level;
            // Any disagreement that does not persist to terminal count restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_entry.sv
// Four-digit hex keypad entry: synchronised switches, debounced enter/clear
// buttons, MS-first digit shift register and a two-state entry FSM.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        sw,
    input  logic              enter_n,
    input  logic              clear_n,
    output logic [DATA_W-1:0] value,
    output logic [2:0]        digit_cnt,
    output logic              full,
    output logic              done
);

    localparam int unsigned N_DIGITS = DATA_W / DIGIT_W;
    localparam logic [2:0]  LAST_CNT = 3'(N_DIGITS - 1);

    logic [DIGIT_W-1:0] sw_s1;
    logic [DIGIT_W-1:0] sw_sync;
    logic               enter_press;
    logic               clear_press;

    entry_state_t       state;
    entry_state_t       state_next;
    logic [DATA_W-1:0]  value_next;
    logic [2:0]         cnt_next;
    logic               done_next;

    hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .raw_n (enter_n),
        .press (enter_press)
    );

    hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .raw_n (clear_n),
        .press (clear_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1     <= '0;
            sw_sync   <= '0;
            state     <= ENTRY;
            value     <= '0;
            digit_cnt <= '0;
            done      <= 1'b0;
        end else begin
            sw_s1     <= sw;
            sw_sync   <= sw_s1;
            state     <= state_next;
            value     <= value_next;
            digit_cnt <= cnt_next;
            done      <= done_next;
        end
    end

    // Clear takes priority so a simultaneous enter is discarded.
    always_comb begin
        state_next = state;
        value_next = value;
        cnt_next   = digit_cnt;
        done_next  = 1'b0;
        if (clear_press) begin
            state_next = ENTRY;
            value_next = '0;
            cnt_next   = '0;
        end else if (enter_press) begin
            if (state == FULL) begin
                value_next = {{(DATA_W-DIGIT_W){1'b0}}, sw_sync};
                cnt_next   = 3'd1;
                state_next = ENTRY;
            end else begin
                value_next = {value[DATA_W-DIGIT_W-1:0], sw_sync};
                cnt_next   = digit_cnt + 3'd1;
                if (digit_cnt == LAST_CNT) begin
                    state_next = FULL;
                    done_next  = 1'b1;
                end
            end
        end
    end

    assign full = (state == FULL);

endmodule

// File: tb/tb_hex_entry.sv
// Scoreboard bench for hex_entry with a short debounce window: stimulus pushes
// expected output updates, a negedge monitor pops and compares them.
module tb_hex_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  sw;
    logic        enter_n;
    logic        clear_n;
    logic [15:0] value;
    logic [2:0]  digit_cnt;
    logic        full;
    logic        done;

    typedef struct packed {
        logic [15:0] v;
        logic [2:0]  c;
        logic        f;
        logic        d;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] mv          = '0;
    int          mc          = 0;

    hex_entry #(.DEBOUNCE_CYCLES(4), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .enter_n   (enter_n),
        .clear_n   (clear_n),
        .value     (value),
        .digit_cnt (digit_cnt),
        .full      (full),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push_enter(input logic [3:0] d);
        exp_t e;
        if (mc == 4) begin
            mv = {12'h000, d};
            mc = 1;
            e.d = 1'b0;
        end else begin
            mv = {mv[11:0], d};
            mc = mc + 1;
            e.d = (mc == 4);
        end
        e.v = mv;
        e.c = 3'(mc);
        e.f = (mc == 4);
        sb.push_back(e);
    endtask

    task automatic push_clear();
        exp_t e;
        mv = '0;
        mc = 0;
        e = '0;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d updates outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic key(input logic [3:0] d, input int hold);
        sw = d;
        repeat (3) @(posedge clk);
        #1 enter_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1 enter_n = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    // Monitor: any change of value/digit_cnt outside reset is a DUT update.
    initial begin
        logic [15:0] pv;
        logic [2:0]  pc;
        exp_t        e;
        pv = '0;
        pc = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = value;
                pc = digit_cnt;
            end else if (value !== pv || digit_cnt !== pc) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_update: got value=%h cnt=%0d done=%b, expected no update",
                             value, digit_cnt, done);
                end else begin
                    e = sb.pop_front();
                    if ({value, digit_cnt, full, done} !== {e.v, e.c, e.f, e.d}) begin
                        miscompares++;
                        $display("FAIL update: got value=%h cnt=%0d full=%b done=%b, expected value=%h cnt=%0d full=%b done=%b",
                                 value, digit_cnt, full, done, e.v, e.c, e.f, e.d);
                    end
                end
                pv = value;
                pc = digit_cnt;
            end else begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_idle: got done=%b with no update, expected 0", done);
                end
            end
        end
    end

    initial begin
        rst     = 1'b0;
        sw      = 4'h0;
        enter_n = 1'b1;
        clear_n = 1'b1;
        #1;
        check("reset_value", 32'(value), 32'h0);
        check("reset_cnt",   32'(digit_cnt), 32'h0);
        check("reset_full",  32'(full), 32'h0);
        check("reset_done",  32'(done), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Four clean digits A,3,F,1
        push_enter(4'hA); key(4'hA, 12);
        push_enter(4'h3); key(4'h3, 12);
        push_enter(4'hF); key(4'hF, 12);
        push_enter(4'h1); key(4'h1, 12);
        wait_drain("a3f1");
        check("a3f1_value", 32'(value), 32'hA3F1);
        check("a3f1_full",  32'(full), 32'h1);

        // Long hold while full starts a new entry, single event
        push_enter(4'h7); key(4'h7, 1000);
        wait_drain("hold");
        check("hold_value", 32'(value), 32'h0007);
        check("hold_full",  32'(full), 32'h0);

        // Bouncing enter then steady press: one digit only
        sw = 4'h5;
        push_enter(4'h5);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 enter_n = (i % 2 == 1);
            repeat (2) @(posedge clk);
        end
        #1 enter_n = 1'b0;
        repeat (12) @(posedge clk);
        #1 enter_n = 1'b1;
        repeat (12) @(posedge clk);
        wait_drain("bounce");
        check("bounce_value", 32'(value), 32'h0075);
        check("bounce_cnt",   32'(digit_cnt), 32'd2);

        // Simultaneous enter and clear: clear wins
        sw = 4'hB;
        push_clear();
        repeat (3) @(posedge clk);
        #1 begin enter_n = 1'b0; clear_n = 1'b0; end
        repeat (12) @(posedge clk);
        #1 begin enter_n = 1'b1; clear_n = 1'b1; end
        repeat (12) @(posedge clk);
        wait_drain("both");
        check("both_value", 32'(value), 32'h0);

        // Reset during debounce of the third digit
        push_enter(4'h1); key(4'h1, 12);
        push_enter(4'h2); key(4'h2, 12);
        wait_drain("pre_rst");
        sw = 4'h3;
        repeat (3) @(posedge clk);
        #1 enter_n = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_value", 32'(value), 32'h0);
        check("async_rst_cnt",   32'(digit_cnt), 32'h0);
        check("async_rst_full",  32'(full), 32'h0);
        mv = '0;
        mc = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        push_enter(4'h3);
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_early_cnt", 32'(digit_cnt), 32'h0);
        repeat (10) @(posedge clk);
        #1 enter_n = 1'b1;
        repeat (12) @(posedge clk);
        wait_drain("post_rst");
        check("post_rst_value", 32'(value), 32'h0003);

        // sw changes right after the enter event; stored digit is the old one
        sw = 4'h9;
        push_enter(4'h9);
        repeat (3) @(posedge clk);
        #1 enter_n = 1'b0;
        repeat (7) @(posedge clk);
        #1 sw = 4'h4;
        repeat (6) @(posedge clk);
        #1 enter_n = 1'b1;
        repeat (12) @(posedge clk);
        wait_drain("sw_change");
        check("sw_change_value", 32'(value), 32'h0039);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
